// File: rtl/cache_bus1_responder.sv
// Cache-side responder for CPU<->cache bus 1: decodes the 2-tact C1/A1/D1 transfer, hands it to the
// core and drives C1_RESPONSE (plus read data). Optional checking: CACHE_BUS1_PROTO_CHECK_EN.
module cache_bus1_responder #(
   parameter int unsigned ADDR1_BUS_SIZE    = 15,
   parameter int unsigned DATA1_BUS_SIZE    = 16,
   parameter int unsigned CTR1_BUS_SIZE     = 3,
   parameter int unsigned CACHE_OFFSET_SIZE = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [ADDR1_BUS_SIZE-1:0]     A1_WIRE,
   inout  wire  [DATA1_BUS_SIZE-1:0]     D1_WIRE,
   inout  wire  [CTR1_BUS_SIZE-1:0]      C1_WIRE,
   output logic                          req_valid,
   input  logic                          req_ready,
   output logic [CTR1_BUS_SIZE-1:0]      req_cmd,
   output logic [ADDR1_BUS_SIZE-1:0]     req_tag_set,
   output logic [CACHE_OFFSET_SIZE-1:0]  req_offset,
   output logic [2*DATA1_BUS_SIZE-1:0]   req_wdata,
   input  logic                          rsp_valid,
   input  logic [2*DATA1_BUS_SIZE-1:0]   rsp_rdata,
   output logic                          PROTO_ERR
);

   localparam logic [CTR1_BUS_SIZE-1:0] CmdNop  = CTR1_BUS_SIZE'(0);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdRd8  = CTR1_BUS_SIZE'(1);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdRd16 = CTR1_BUS_SIZE'(2);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdRd32 = CTR1_BUS_SIZE'(3);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdWr8  = CTR1_BUS_SIZE'(5);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdWr16 = CTR1_BUS_SIZE'(6);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdWr32 = CTR1_BUS_SIZE'(7);
   localparam logic [CTR1_BUS_SIZE-1:0] CmdResp = CTR1_BUS_SIZE'(7);
   localparam logic [DATA1_BUS_SIZE-1:0] ByteMask = DATA1_BUS_SIZE'(8'hFF);

   typedef enum logic [2:0] {StIdle, StAddr2, StTurn, StWait, StResp1, StResp2, StRel} state_e;

   state_e                          state_q, state_d;
   logic [CTR1_BUS_SIZE-1:0]        cmd_q, cmd_d;
   logic [ADDR1_BUS_SIZE-1:0]       tag_q, tag_d;
   logic [CACHE_OFFSET_SIZE-1:0]    off_q, off_d;
   logic [DATA1_BUS_SIZE-1:0]       wlo_q, wlo_d, whi_q, whi_d;
   logic [2*DATA1_BUS_SIZE-1:0]     rdata_q, rdata_d;
   logic                            req_valid_q, req_valid_d;
   logic                            idle_resp;
   logic                            c1_oe, d1_oe;
   logic [DATA1_BUS_SIZE-1:0]       d1_out;

`ifdef CACHE_BUS1_PROTO_CHECK_EN
   logic err_q, err_d;

   assign idle_resp = (C1_WIRE == CmdResp);

   // A released C1 reads as NOP (bus keeper low), so any other value in TURN means the CPU still drives.
   always_comb begin
      err_d = err_q;
      if (state_q == StIdle && idle_resp)     err_d = 1'b1;
      if (state_q == StTurn && C1_WIRE != CmdNop) err_d = 1'b1;
      if (state_q != StWait && rsp_valid)     err_d = 1'b1;
   end

   always_ff @(negedge CLK or negedge RESET) begin
      if (!RESET) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign PROTO_ERR = err_q;
`else
   assign idle_resp = 1'b0;
   assign PROTO_ERR = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      tag_d       = tag_q;
      off_d       = off_q;
      wlo_d       = wlo_q;
      whi_d       = whi_q;
      rdata_d     = rdata_q;
      req_valid_d = req_valid_q;
      case (state_q)
         StIdle: begin
            if (C1_WIRE != CmdNop && !idle_resp) begin
               cmd_d = C1_WIRE;
               tag_d = A1_WIRE;
               whi_d = '0;
               if (C1_WIRE == CmdWr8)                           wlo_d = D1_WIRE & ByteMask;
               else if (C1_WIRE == CmdWr16 || C1_WIRE == CmdWr32) wlo_d = D1_WIRE;
               else                                              wlo_d = '0;
               state_d = StAddr2;
            end
         end
         StAddr2: begin
            off_d = A1_WIRE[CACHE_OFFSET_SIZE-1:0];
            if (cmd_q == CmdWr32) whi_d = D1_WIRE;
            state_d = StTurn;
         end
         StTurn: begin
            req_valid_d = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            if (req_valid_q && req_ready) req_valid_d = 1'b0;
            // A response only counts once the request is (or is being) accepted.
            if (rsp_valid && (!req_valid_q || req_ready)) begin
               rdata_d = rsp_rdata;
               state_d = StResp1;
            end
         end
         StResp1: state_d = (cmd_q == CmdRd32) ? StResp2 : StRel;
         StResp2: state_d = StRel;
         StRel:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(negedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= StIdle;
         cmd_q       <= '0;
         tag_q       <= '0;
         off_q       <= '0;
         wlo_q       <= '0;
         whi_q       <= '0;
         rdata_q     <= '0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         tag_q       <= tag_d;
         off_q       <= off_d;
         wlo_q       <= wlo_d;
         whi_q       <= whi_d;
         rdata_q     <= rdata_d;
         req_valid_q <= req_valid_d;
      end
   end

   always_comb begin
      c1_oe  = (state_q == StResp1) || (state_q == StResp2);
      d1_oe  = 1'b0;
      d1_out = rdata_q[DATA1_BUS_SIZE-1:0];
      if (state_q == StResp2) begin
         d1_oe  = 1'b1;
         d1_out = rdata_q[2*DATA1_BUS_SIZE-1:DATA1_BUS_SIZE];
      end else if (state_q == StResp1) begin
         d1_oe = (cmd_q == CmdRd8) || (cmd_q == CmdRd16) || (cmd_q == CmdRd32);
         if (cmd_q == CmdRd8) d1_out = rdata_q[DATA1_BUS_SIZE-1:0] & ByteMask;
      end
   end

   assign C1_WIRE = c1_oe ? CmdResp : 'z;
   assign D1_WIRE = d1_oe ? d1_out : 'z;

   assign req_valid   = req_valid_q;
   assign req_cmd     = cmd_q;
   assign req_tag_set = tag_q;
   assign req_offset  = off_q;
   assign req_wdata   = {whi_q, wlo_q};

endmodule

// File: tb/tb_cache_bus1_responder.sv
// Directed bench for cache_bus1_responder; define CACHE_BUS1_PROTO_CHECK_EN to also cover PROTO_ERR.
module tb_cache_bus1_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [14:0] a1 = '0;
   logic [15:0] d1_drv = '0;
   logic        d1_oe = 1'b0;
   logic [2:0]  c1_drv = '0;
   logic        c1_oe = 1'b0;
   wire  [15:0] d1;
   wire  [2:0]  c1;
   logic        req_valid, req_ready = 1'b0;
   logic [2:0]  req_cmd;
   logic [14:0] req_tag_set;
   logic [3:0]  req_offset;
   logic [31:0] req_wdata;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_rdata = '0;
   logic        proto_err;
   int          total = 0;
   int          bad = 0;

   assign d1 = d1_oe ? d1_drv : 16'bz;
   assign c1 = c1_oe ? c1_drv : 3'bz;

   always #5 clk = ~clk;

   cache_bus1_responder dut (
      .CLK         (clk),
      .RESET       (rst_n),
      .A1_WIRE     (a1),
      .D1_WIRE     (d1),
      .C1_WIRE     (c1),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_cmd     (req_cmd),
      .req_tag_set (req_tag_set),
      .req_offset  (req_offset),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .PROTO_ERR   (proto_err)
   );

   // Released nets read as z in a 4-state simulator and as 0 in a 2-state one.
   function automatic logic c1_free();
      return (c1 === 3'bzzz) || (c1 === 3'b000);
   endfunction
   function automatic logic d1_free();
      return (d1 === 16'hzzzz) || (d1 === 16'h0000);
   endfunction

   // Drives the two command tacts and the TURN tact; returns 1 time unit after TURN ends (in WAIT).
   task automatic send(input logic [2:0] cmd, input logic [14:0] a_hi, input logic [14:0] a_lo,
                       input logic [15:0] d_lo, input logic [15:0] d_hi, input logic keep_c1);
      @(posedge clk);
      c1_oe = 1'b1; c1_drv = cmd; a1 = a_hi;
      d1_oe = (cmd >= 3'd5); d1_drv = d_lo;
      @(posedge clk);
      c1_drv = 3'd1; a1 = a_lo; d1_drv = d_hi;
      @(posedge clk);
      c1_oe = keep_c1; c1_drv = 3'd2; d1_oe = 1'b0;
      @(negedge clk); #1;
      c1_oe = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", req_valid); end
      total++; if (req_cmd !== 3'd0 || req_tag_set !== 15'd0 || req_offset !== 4'd0) begin
         bad++; $display("FAIL reset_req got=%h/%h/%h want=0/0/0", req_cmd, req_tag_set, req_offset); end
      total++; if (req_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", req_wdata); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", proto_err); end
      total++; if (!c1_free() || !d1_free()) begin bad++; $display("FAIL reset_bus got=%b/%h want=z", c1, d1); end
      @(posedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_inv_line();
      send(3'd4, 15'd1, 15'd2, 16'h0, 16'h0, 1'b0);
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL inv_valid got=%b want=1", req_valid); end
      total++; if (req_cmd !== 3'd4 || req_tag_set !== 15'd1 || req_offset !== 4'd2) begin
         bad++; $display("FAIL inv_req got=%h/%h/%h want=4/1/2", req_cmd, req_tag_set, req_offset); end
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h1111_2222;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      total++; if (c1 !== 3'd7) begin bad++; $display("FAIL inv_resp got=%h want=7", c1); end
      total++; if (!d1_free()) begin bad++; $display("FAIL inv_d1 got=%h want=z", d1); end
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL inv_drop got=%b want=0", req_valid); end
      @(negedge clk); #1;
      total++; if (!c1_free()) begin bad++; $display("FAIL inv_rel got=%h want=z", c1); end
      @(negedge clk);
   endtask

   task automatic test_wr32();
      send(3'd7, 15'h0123, 15'h0005, 16'hBEEF, 16'hDEAD, 1'b0);
      total++; if (req_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr32_wdata got=%h want=deadbeef", req_wdata); end
      total++; if (req_cmd !== 3'd7 || req_tag_set !== 15'h0123 || req_offset !== 4'h5) begin
         bad++; $display("FAIL wr32_req got=%h/%h/%h want=7/123/5", req_cmd, req_tag_set, req_offset); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL wr32_hold%0d got=%b want=1", i, req_valid); end
      end
      req_ready = 1'b1;
      @(negedge clk); #1;
      req_ready = 1'b0;
      total++; if (req_valid !== 1'b0 || !c1_free()) begin
         bad++; $display("FAIL wr32_accept got=%b/%h want=0/z", req_valid, c1); end
      rsp_valid = 1'b1;
      @(negedge clk); #1;
      rsp_valid = 1'b0;
      total++; if (c1 !== 3'd7 || !d1_free()) begin bad++; $display("FAIL wr32_resp got=%h/%h want=7/z", c1, d1); end
      @(negedge clk); #1;
      total++; if (!c1_free()) begin bad++; $display("FAIL wr32_rel got=%h want=z", c1); end
      @(negedge clk);
   endtask

   task automatic test_rd32();
      send(3'd3, 15'h4A5A, 15'h7FF3, 16'h0, 16'h0, 1'b0);
      total++; if (req_offset !== 4'h3 || req_wdata !== 32'h0) begin
         bad++; $display("FAIL rd32_req got=%h/%h want=3/0", req_offset, req_wdata); end
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hCAFE1234;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      total++; if (c1 !== 3'd7 || d1 !== 16'h1234) begin bad++; $display("FAIL rd32_lo got=%h/%h want=7/1234", c1, d1); end
      @(negedge clk); #1;
      total++; if (c1 !== 3'd7 || d1 !== 16'hCAFE) begin bad++; $display("FAIL rd32_hi got=%h/%h want=7/cafe", c1, d1); end
      @(negedge clk); #1;
      total++; if (!c1_free() || !d1_free()) begin bad++; $display("FAIL rd32_rel got=%h/%h want=z", c1, d1); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      send(3'd1, 15'h0055, 15'h0001, 16'h0, 16'h0, 1'b0);
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hFFFFFFA5;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      total++; if (c1 !== 3'd7 || d1 !== 16'h00A5) begin bad++; $display("FAIL rd8_data got=%h/%h want=7/00a5", c1, d1); end
      @(negedge clk); #1;
      total++; if (!c1_free() || !d1_free()) begin bad++; $display("FAIL rd8_rel got=%h/%h want=z", c1, d1); end
      @(negedge clk);
      send(3'd2, 15'h0066, 15'h0002, 16'h0, 16'h0, 1'b0);
      total++; if (req_valid !== 1'b1 || req_cmd !== 3'd2 || req_tag_set !== 15'h0066) begin
         bad++; $display("FAIL b2b_req got=%b/%h/%h want=1/2/66", req_valid, req_cmd, req_tag_set); end
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h56789ABC;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      total++; if (c1 !== 3'd7 || d1 !== 16'h9ABC) begin bad++; $display("FAIL rd16_data got=%h/%h want=7/9abc", c1, d1); end
      @(negedge clk); #1;
      total++; if (!c1_free() || !d1_free()) begin bad++; $display("FAIL rd16_rel got=%h/%h want=z", c1, d1); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      send(3'd3, 15'h0011, 15'h0004, 16'h0, 16'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++; if (req_valid !== 1'b0 || req_cmd !== 3'd0 || req_tag_set !== 15'd0) begin
         bad++; $display("FAIL rstmid_req got=%b/%h/%h want=0/0/0", req_valid, req_cmd, req_tag_set); end
      total++; if (!c1_free() || !d1_free()) begin bad++; $display("FAIL rstmid_bus got=%h/%h want=z", c1, d1); end
      @(posedge clk); rst_n = 1'b1;
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hCAFE1234;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      total++; if (!c1_free() || req_valid !== 1'b0) begin
         bad++; $display("FAIL late_rsp got=%h/%b want=z/0", c1, req_valid); end
      @(negedge clk);
      send(3'd3, 15'h0022, 15'h0001, 16'h0, 16'h0, 1'b0);
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_F00D;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      total++; if (c1 !== 3'd7) begin bad++; $display("FAIL rstresp_pre got=%h want=7", c1); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (!c1_free() || !d1_free()) begin bad++; $display("FAIL rstresp_bus got=%h/%h want=z", c1, d1); end
      @(posedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef CACHE_BUS1_PROTO_CHECK_EN
   task automatic test_proto();
      @(posedge clk); c1_oe = 1'b1; c1_drv = 3'd7; a1 = 15'h0033;
      @(negedge clk); #1;
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_idle got=%b want=1", proto_err); end
      c1_oe = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      total++; if (req_valid !== 1'b0 || req_cmd !== 3'd0) begin
         bad++; $display("FAIL perr_noreq got=%b/%h want=0/0", req_valid, req_cmd); end
      rst_n = 1'b0; #1;
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_clear got=%b want=0", proto_err); end
      @(posedge clk); rst_n = 1'b1;
      @(negedge clk);
      send(3'd1, 15'h0044, 15'h0000, 16'h0, 16'h0, 1'b1);
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_turn got=%b want=1", proto_err); end
      rst_n = 1'b0;
      @(posedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask
`else
   task automatic test_resp_code_idle();
      send(3'd7, 15'h0033, 15'h0006, 16'h1234, 16'h5678, 1'b0);
      total++; if (req_valid !== 1'b1 || req_cmd !== 3'd7) begin
         bad++; $display("FAIL c7_as_wr32 got=%b/%h want=1/7", req_valid, req_cmd); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_tied got=%b want=0", proto_err); end
      req_ready = 1'b1; rsp_valid = 1'b1;
      @(negedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_inv_line();
      test_wr32();
      test_rd32();
      test_back_to_back();
      test_reset_mid();
`ifdef CACHE_BUS1_PROTO_CHECK_EN
      test_proto();
`else
      test_resp_code_idle();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
